control_conmutacion_baterias: RTL and testbench

Sequencing controller for the two-battery power path watched by the battery monitor. It samples the 4-bit charge of each battery, filters low-charge readings, and connects exactly one battery to the load. When the active battery becomes critical, it switches to the other battery with a break-before-make dead time. It enters a safe shutdown state when neither battery can supply the load.

---
 rtl/control_conmutacion_baterias.sv | 142 ++++++++++++++
 tb/tb_control_conmutacion_baterias.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/control_conmutacion_baterias.sv
// Two-battery power path sequencer: filters critical charge readings,
// connects one battery at a time and switches over with a dead time.
module control_conmutacion_baterias #(
    parameter int UMBRAL_CRITICO = 3,
    parameter int HISTERESIS     = 2,
    parameter int FILTRO         = 3,
    parameter int TIEMPO_MUERTO  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       habilitar,
    input  logic [3:0] carga_bateria1,
    input  logic [3:0] carga_bateria2,
    output logic       conecta_bat1,
    output logic       conecta_bat2,
    output logic       apagado_seguro,
    output logic [2:0] estado,
    output logic [7:0] conmutaciones
);

    typedef enum logic [2:0] {
        REPOSO      = 3'd0,
        BAT1        = 3'd1,
        BAT2        = 3'd2,
        CONMUTA_A1  = 3'd3,
        CONMUTA_A2  = 3'd4,
        SIN_ENERGIA = 3'd5
    } estado_t;

    localparam logic [3:0] LP_UMBRAL = 4'(UMBRAL_CRITICO);
    localparam logic [4:0] LP_APTO   = 5'(UMBRAL_CRITICO + 1 + HISTERESIS);
    localparam logic [3:0] LP_FILTRO = 4'(FILTRO);
    localparam logic [3:0] LP_MUERTO = 4'(TIEMPO_MUERTO - 1);

    estado_t    r_estado;
    logic [3:0] r_filtro1;
    logic [3:0] r_filtro2;
    logic [3:0] r_muerto;
    logic [7:0] r_conmut;

    logic w_critico1;
    logic w_critico2;
    logic w_apto1;
    logic w_apto2;
    logic w_agotada1;
    logic w_agotada2;

    assign w_critico1 = (carga_bateria1 <= LP_UMBRAL);
    assign w_critico2 = (carga_bateria2 <= LP_UMBRAL);
    assign w_apto1    = ({1'b0, carga_bateria1} >= LP_APTO);
    assign w_apto2    = ({1'b0, carga_bateria2} >= LP_APTO);
    assign w_agotada1 = (r_filtro1 == LP_FILTRO);
    assign w_agotada2 = (r_filtro2 == LP_FILTRO);

    // Count consecutive critical samples per battery, saturating at FILTRO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filtro1 <= '0;
            r_filtro2 <= '0;
        end else begin
            if (!w_critico1)
                r_filtro1 <= '0;
            else if (r_filtro1 != LP_FILTRO)
                r_filtro1 <= r_filtro1 + 4'd1;
            if (!w_critico2)
                r_filtro2 <= '0;
            else if (r_filtro2 != LP_FILTRO)
                r_filtro2 <= r_filtro2 + 4'd1;
        end
    end

    // Battery sequencing FSM with dead-time counter and switchover count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= REPOSO;
            r_muerto <= '0;
            r_conmut <= '0;
        end else begin
            unique case (r_estado)
                REPOSO: begin
                    r_muerto <= '0;
                    if (habilitar) begin
                        if (w_critico1 && w_critico2)
                            r_estado <= SIN_ENERGIA;
                        else if (carga_bateria1 >= carga_bateria2)
                            r_estado <= BAT1;
                        else
                            r_estado <= BAT2;
                    end
                end
                BAT1: begin
                    if (!habilitar) begin
                        r_estado <= REPOSO;
                    end else if (w_agotada1 && w_apto2) begin
                        r_estado <= CONMUTA_A2;
                        r_muerto <= LP_MUERTO;
                    end else if (w_agotada1 && w_critico2) begin
                        r_estado <= SIN_ENERGIA;
                    end
                end
                BAT2: begin
                    if (!habilitar) begin
                        r_estado <= REPOSO;
                    end else if (w_agotada2 && w_apto1) begin
                        r_estado <= CONMUTA_A1;
                        r_muerto <= LP_MUERTO;
                    end else if (w_agotada2 && w_critico1) begin
                        r_estado <= SIN_ENERGIA;
                    end
                end
                CONMUTA_A1, CONMUTA_A2: begin
                    if (!habilitar) begin
                        r_estado <= REPOSO;
                        r_muerto <= '0;
                    end else if (r_muerto == 4'd0) begin
                        r_estado <= (r_estado == CONMUTA_A1) ? BAT1 : BAT2;
                        if (r_conmut != 8'hFF)
                            r_conmut <= r_conmut + 8'd1;
                    end else begin
                        r_muerto <= r_muerto - 4'd1;
                    end
                end
                SIN_ENERGIA: begin
                    if (!habilitar)
                        r_estado <= REPOSO;
                end
                default: begin
                    r_estado <= REPOSO;
                    r_muerto <= '0;
                end
            endcase
        end
    end

    // Outputs decode only the state flop, so the switches stay exclusive
    assign conecta_bat1   = (r_estado == BAT1);
    assign conecta_bat2   = (r_estado == BAT2);
    assign apagado_seguro = (r_estado == SIN_ENERGIA);
    assign estado         = r_estado;
    assign conmutaciones  = r_conmut;

endmodule

// File: tb/tb_control_conmutacion_baterias.sv
// Directed self-checking bench for the battery switchover controller.
// Expected values are hand-computed from the cycle timing.
module tb_control_conmutacion_baterias;

    logic       clk;
    logic       rst;
    logic       habilitar;
    logic [3:0] carga_bateria1;
    logic [3:0] carga_bateria2;
    logic       conecta_bat1;
    logic       conecta_bat2;
    logic       apagado_seguro;
    logic [2:0] estado;
    logic [7:0] conmutaciones;

    int n_checks;
    int n_errors;

    control_conmutacion_baterias dut (
        .clk            (clk),
        .rst            (rst),
        .habilitar      (habilitar),
        .carga_bateria1 (carga_bateria1),
        .carga_bateria2 (carga_bateria2),
        .conecta_bat1   (conecta_bat1),
        .conecta_bat2   (conecta_bat2),
        .apagado_seguro (apagado_seguro),
        .estado         (estado),
        .conmutaciones  (conmutaciones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chequear(input string tag, input logic [31:0] obs,
                            input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ver(input string tag, input logic [2:0] e,
                       input logic c1, input logic c2,
                       input logic ap, input logic [7:0] n);
        chequear({tag, ".estado"}, 32'(estado), 32'(e));
        chequear({tag, ".bat1"}, 32'(conecta_bat1), 32'(c1));
        chequear({tag, ".bat2"}, 32'(conecta_bat2), 32'(c2));
        chequear({tag, ".apagado"}, 32'(apagado_seguro), 32'(ap));
        chequear({tag, ".conmut"}, 32'(conmutaciones), 32'(n));
    endtask

    // Both switches closed at once is never allowed
    always @(negedge clk) begin
        chequear("exclusion", 32'(conecta_bat1 & conecta_bat2), 32'd0);
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        habilitar = 1'b0;
        carga_bateria1 = 4'd8;
        carga_bateria2 = 4'd5;
        tick();
        tick();
        rst = 1'b0;
        ver("reset", 3'd0, 0, 0, 0, 8'd0);

        habilitar = 1'b1;
        tick();
        ver("arranque", 3'd1, 1, 0, 0, 8'd0);

        habilitar = 1'b0;
        tick();
        ver("deshab", 3'd0, 0, 0, 0, 8'd0);
        carga_bateria1 = 4'd5;
        carga_bateria2 = 4'd9;
        habilitar = 1'b1;
        tick();
        ver("elige2", 3'd2, 0, 1, 0, 8'd0);
        habilitar = 1'b0;
        tick();
        carga_bateria1 = 4'd9;
        carga_bateria2 = 4'd9;
        habilitar = 1'b1;
        tick();
        ver("empate", 3'd1, 1, 0, 0, 8'd0);

        carga_bateria2 = 4'd10;
        carga_bateria1 = 4'd2;
        tick();
        tick();
        carga_bateria1 = 4'd6;
        tick();
        ver("filtro_borra", 3'd1, 1, 0, 0, 8'd0);
        carga_bateria1 = 4'd2;
        tick();
        tick();
        tick();
        ver("agotada_n2", 3'd1, 1, 0, 0, 8'd0);
        tick();
        ver("muerto0", 3'd4, 0, 0, 0, 8'd0);
        tick();
        tick();
        tick();
        ver("muerto3", 3'd4, 0, 0, 0, 8'd0);
        tick();
        ver("conmuta_b2", 3'd2, 0, 1, 0, 8'd1);

        habilitar = 1'b0;
        tick();
        carga_bateria1 = 4'd10;
        habilitar = 1'b1;
        tick();
        ver("vuelve_b1", 3'd1, 1, 0, 0, 8'd1);
        carga_bateria1 = 4'd2;
        tick();
        tick();
        tick();
        tick();
        ver("conmuta_a2", 3'd4, 0, 0, 0, 8'd1);
        habilitar = 1'b0;
        tick();
        ver("aborta", 3'd0, 0, 0, 0, 8'd1);

        carga_bateria1 = 4'd10;
        carga_bateria2 = 4'd3;
        habilitar = 1'b1;
        tick();
        ver("b1_sin", 3'd1, 1, 0, 0, 8'd1);
        carga_bateria1 = 4'd2;
        tick();
        tick();
        tick();
        ver("sin_n2", 3'd1, 1, 0, 0, 8'd1);
        tick();
        ver("sin_energia", 3'd5, 0, 0, 1, 8'd1);
        tick();
        ver("sin_retiene", 3'd5, 0, 0, 1, 8'd1);
        habilitar = 1'b0;
        tick();
        ver("sin_sale", 3'd0, 0, 0, 0, 8'd1);

        carga_bateria1 = 4'd10;
        carga_bateria2 = 4'd4;
        habilitar = 1'b1;
        tick();
        carga_bateria1 = 4'd2;
        for (int i = 0; i < 5; i++) tick();
        ver("no_apto", 3'd1, 1, 0, 0, 8'd1);

        habilitar = 1'b0;
        tick();
        carga_bateria1 = 4'd3;
        carga_bateria2 = 4'd3;
        habilitar = 1'b1;
        tick();
        ver("ambas_crit", 3'd5, 0, 0, 1, 8'd1);
        habilitar = 1'b0;
        tick();

        carga_bateria1 = 4'd4;
        carga_bateria2 = 4'd9;
        habilitar = 1'b1;
        tick();
        ver("b2_rst", 3'd2, 0, 1, 0, 8'd1);
        rst = 1'b1;
        tick();
        ver("rst_b2", 3'd0, 0, 0, 0, 8'd0);
        rst = 1'b0;
        habilitar = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
